// File: rtl/slt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slt_arbiter
//  Description : Two-requester round-robin arbiter in front of one shared
//                subtractor-based signed less-than comparator. The result is
//                registered in a one-entry output buffer and tagged with the
//                winning requester ID.
//  Options     : SLT_ARBITER_UNSIGNED_EN adds per-request unsigned-compare
//                select inputs (req_uns0/1) and the rsp_uns output.
//  Revision    : 1.0 - initial release
// ============================================================================
module slt_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
`ifdef SLT_ARBITER_UNSIGNED_EN
    input  logic             req_uns0,
    input  logic             req_uns1,
    output logic             rsp_uns,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_lt,
    output logic             rsp_id,
    output logic [CNT_W-1:0] done_count
);

    // Buffer state: the encoding is the response-valid flag itself.
    localparam logic [0:0]       c_ST_EMPTY = 1'b0;
    localparam logic [0:0]       c_ST_FULL  = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_prio;
    logic             r_lt;
    logic             r_id;
    logic [CNT_W-1:0] r_cnt;

    logic             w_can_accept;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_drain;
    logic             w_sel;
    logic [N-1:0]     w_a;
    logic [N-1:0]     w_b;
    logic [N-1:0]     w_diff;
    logic             w_lt_signed;
    logic             w_lt;

    assign rsp_valid  = (r_state == c_ST_FULL);
    assign rsp_lt     = r_lt;
    assign rsp_id     = r_id;
    assign done_count = r_cnt;

    // The buffer can take a new result when empty or when it drains this cycle.
    assign w_can_accept = ~rsp_valid | rsp_ready;
    assign w_drain      = rsp_valid & rsp_ready;

    // Round-robin: a lone requester always wins; on contention r_prio picks.
    assign w_grant[0] = req_valid[0] & (~req_valid[1] | ~r_prio);
    assign w_grant[1] = req_valid[1] & (~req_valid[0] |  r_prio);

    // Ready is forced low while reset is held, independent of buffer state.
    assign req_ready = {2{~rst & w_can_accept}} & w_grant;
    assign w_accept  = |req_ready;
    assign w_sel     = w_grant[1];

    assign w_a = w_sel ? req_a1 : req_a0;
    assign w_b = w_sel ? req_b1 : req_b0;

    // Signed compare from the adder sign bit, corrected when operand signs
    // differ so that subtraction overflow never produces a wrong answer.
    assign w_lt_signed = (w_a[N-1] & ~w_b[N-1]) |
                         (~(w_a[N-1] ^ w_b[N-1]) & w_diff[N-1]);

`ifdef SLT_ARBITER_UNSIGNED_EN
    logic [N:0] w_sum;
    logic       w_uns;
    logic       r_uns;

    assign w_sum   = {1'b0, w_a} + {1'b0, ~w_b} + {{N{1'b0}}, 1'b1};
    assign w_diff  = w_sum[N-1:0];
    assign w_uns   = w_sel ? req_uns1 : req_uns0;
    // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
    assign w_lt    = w_uns ? ~w_sum[N] : w_lt_signed;
    assign rsp_uns = r_uns;

    // Compare-mode tag travels with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uns <= 1'b0;
        end else if (w_accept) begin
            r_uns <= w_uns;
        end
    end
`else
    assign w_diff = w_a + ~w_b + {{(N-1){1'b0}}, 1'b1};
    assign w_lt   = w_lt_signed;
`endif

    // Buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next buffer state: fill on accept, empty on a drain with no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_accept)             w_state_nxt = c_ST_FULL;
            c_ST_FULL:  if (w_drain && !w_accept) w_state_nxt = c_ST_EMPTY;
            default:                              w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // Capture result and tag on accept; winner drops to lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lt   <= 1'b0;
            r_id   <= 1'b0;
            r_prio <= 1'b0;
        end else if (w_accept) begin
            r_lt   <= w_lt;
            r_id   <= w_sel;
            r_prio <= ~w_sel;
        end
    end

    // Count completed response handshakes; wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire
